// File: rtl/cgol_pkg.sv
// rtl/cgol_pkg.sv - shared board type, FSM encoding and default seed for the CGOL scheduler
package cgol_pkg;

    localparam int unsigned N_CELLS = 64;

    typedef logic [N_CELLS-1:0] board_t;

    typedef enum logic [2:0] {
        ST_SEED,
        ST_SHOW,
        ST_WAIT_LED,
        ST_HOLD,
        ST_COMPUTE,
        ST_WAIT_ENG,
        ST_COMMIT
    } sched_state_t;

    // Horizontal blinker on row 2, columns 3..5
    localparam board_t DEFAULT_SEED = 64'h0000_0000_0038_0000;

endpackage

// File: rtl/cgol_period_timer.sv
// rtl/cgol_period_timer.sv - generation period timer: restartable, saturates at PERIOD-1
module cgol_period_timer #(
    parameter int unsigned PERIOD = 6_000_000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_restart,
    output logic o_expired
);

    localparam int unsigned W = (PERIOD > 1) ? $clog2(PERIOD) : 1;
    localparam logic [W-1:0] LAST = W'(PERIOD - 1);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (i_restart) begin
            count_d = '0;
        end else if (count_q < LAST) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign o_expired = (count_q >= LAST);

endmodule

// File: rtl/cgol_generation_scheduler.sv
// rtl/cgol_generation_scheduler.sv - sequences seed, compute, commit and LED display of one Life board
module cgol_generation_scheduler
    import cgol_pkg::*;
#(
    parameter int unsigned GEN_PERIOD = 6_000_000,
    parameter board_t      SEED       = DEFAULT_SEED,
    parameter int unsigned TIMEOUT    = 1_000_000
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               i_pause,
    input  logic               i_step,
    input  logic               i_reseed,
    output logic               o_eng_start,
    output logic [N_CELLS-1:0] o_board,
    input  logic               i_eng_done,
    input  logic [N_CELLS-1:0] i_eng_board,
    output logic               o_led_start,
    output logic [N_CELLS-1:0] o_led_frame,
    input  logic               i_led_done,
    output logic [15:0]        o_generation,
    output logic               o_stable,
    output logic               o_extinct,
    output logic               o_error
);

    localparam int unsigned TMO_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);

    sched_state_t     state_q, state_d;
    board_t           board_q, board_d;
    board_t           next_q, next_d;
    board_t           frame_q, frame_d;
    logic             led_start_q, led_start_d;
    logic [15:0]      gen_q, gen_d;
    logic             stable_q, stable_d;
    logic             extinct_q, extinct_d;
    logic             error_q, error_d;
    logic             step_pend_q, step_pend_d;
    logic             reseed_pend_q, reseed_pend_d;
    logic [TMO_W-1:0] tmo_q, tmo_d;
    logic             tmr_restart;
    logic             tmr_expired;
    logic             tmo_expired;
    logic             eng_start;

    cgol_period_timer #(
        .PERIOD (GEN_PERIOD)
    ) u_period_timer (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_restart (tmr_restart),
        .o_expired (tmr_expired)
    );

    assign tmo_expired = (tmo_q >= TMO_LAST);

    always_comb begin
        state_d       = state_q;
        board_d       = board_q;
        next_d        = next_q;
        frame_d       = frame_q;
        led_start_d   = 1'b0;
        gen_d         = gen_q;
        stable_d      = stable_q;
        extinct_d     = extinct_q;
        error_d       = error_q;
        // A step only means something while paused; otherwise it is dropped
        step_pend_d   = i_pause ? (step_pend_q | i_step) : 1'b0;
        reseed_pend_d = reseed_pend_q | i_reseed;
        tmo_d         = tmo_expired ? tmo_q : tmo_q + 1'b1;
        tmr_restart   = 1'b0;
        eng_start     = 1'b0;

        case (state_q)
            ST_SEED: begin
                board_d   = SEED;
                gen_d     = '0;
                stable_d  = 1'b0;
                extinct_d = 1'b0;
                state_d   = ST_SHOW;
            end
            ST_SHOW: begin
                frame_d     = board_q;
                led_start_d = 1'b1;
                tmr_restart = 1'b1;
                tmo_d       = '0;
                state_d     = ST_WAIT_LED;
            end
            ST_WAIT_LED: begin
                if (i_led_done) begin
                    state_d = ST_HOLD;
                end else if (tmo_expired) begin
                    error_d = 1'b1;
                    state_d = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if ((tmr_expired && !i_pause) || (i_pause && step_pend_q)) begin
                    step_pend_d = 1'b0;
                    if (reseed_pend_q) begin
                        reseed_pend_d = i_reseed;
                        state_d       = ST_SEED;
                    end else begin
                        state_d = ST_COMPUTE;
                    end
                end
            end
            ST_COMPUTE: begin
                eng_start = 1'b1;
                tmo_d     = '0;
                state_d   = ST_WAIT_ENG;
            end
            ST_WAIT_ENG: begin
                if (i_eng_done) begin
                    next_d  = i_eng_board;
                    state_d = ST_COMMIT;
                end else if (tmo_expired) begin
                    // Engine lost: show the unchanged board again and carry on
                    error_d = 1'b1;
                    state_d = ST_SHOW;
                end
            end
            ST_COMMIT: begin
                stable_d  = (next_q == board_q);
                extinct_d = (next_q == '0);
                board_d   = next_q;
                gen_d     = gen_q + 16'd1;
                state_d   = ST_SHOW;
            end
            default: begin
                state_d = ST_SEED;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_SEED;
            board_q       <= SEED;
            next_q        <= '0;
            frame_q       <= '0;
            led_start_q   <= 1'b0;
            gen_q         <= '0;
            stable_q      <= 1'b0;
            extinct_q     <= 1'b0;
            error_q       <= 1'b0;
            step_pend_q   <= 1'b0;
            reseed_pend_q <= 1'b0;
            tmo_q         <= '0;
        end else begin
            state_q       <= state_d;
            board_q       <= board_d;
            next_q        <= next_d;
            frame_q       <= frame_d;
            led_start_q   <= led_start_d;
            gen_q         <= gen_d;
            stable_q      <= stable_d;
            extinct_q     <= extinct_d;
            error_q       <= error_d;
            step_pend_q   <= step_pend_d;
            reseed_pend_q <= reseed_pend_d;
            tmo_q         <= tmo_d;
        end
    end

    // Start pulse is registered so it lines up with the frame it announces
    assign o_led_start  = led_start_q;
    assign o_led_frame  = frame_q;
    assign o_eng_start  = eng_start;
    assign o_board      = board_q;
    assign o_generation = gen_q;
    assign o_stable     = stable_q;
    assign o_extinct    = extinct_q;
    assign o_error      = error_q;

endmodule

// File: tb/tb_cgol_generation_scheduler.sv
// tb/tb_cgol_generation_scheduler.sv - bench for cgol_generation_scheduler with engine/driver models
module tb_cgol_generation_scheduler;

    localparam int P  = 100;
    localparam int TO = 50;
    localparam logic [63:0] S0   = 64'h0000_0000_0038_0000;
    localparam logic [63:0] VERT = 64'h0000_0000_1010_1000;

    logic        clk;
    logic        rst_n;
    logic        i_pause, i_step, i_reseed;
    logic        o_eng_start;
    logic [63:0] o_board;
    logic        i_eng_done;
    logic [63:0] i_eng_board;
    logic        o_led_start;
    logic [63:0] o_led_frame;
    logic        i_led_done;
    logic [15:0] o_generation;
    logic        o_stable, o_extinct, o_error;

    int n_vec = 0;
    int n_err = 0;

    int cyc = 0;
    int led_cnt = 0, eng_cnt = 0;
    int last_led_cyc = 0, last_eng_cyc = 0;
    logic [63:0] last_frame = '0;
    int led_dly = 10, eng_dly = 5, eng_mode = 0;
    int led_down = 0, eng_down = 0;
    logic [63:0] eng_resp = '0, eng_pending = '0;

    logic [63:0] exp_board;
    int exp_gen;

    cgol_generation_scheduler #(
        .GEN_PERIOD (P),
        .TIMEOUT    (TO)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_pause      (i_pause),
        .i_step       (i_step),
        .i_reseed     (i_reseed),
        .o_eng_start  (o_eng_start),
        .o_board      (o_board),
        .i_eng_done   (i_eng_done),
        .i_eng_board  (i_eng_board),
        .o_led_start  (o_led_start),
        .o_led_frame  (o_led_frame),
        .i_led_done   (i_led_done),
        .o_generation (o_generation),
        .o_stable     (o_stable),
        .o_extinct    (o_extinct),
        .o_error      (o_error)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Conway's rule on an 8x8 board with dead cells beyond the edges
    function automatic logic [63:0] life_next(input logic [63:0] b);
        logic [63:0] n;
        int cnt;
        n = '0;
        for (int r = 0; r < 8; r++) begin
            for (int c = 0; c < 8; c++) begin
                cnt = 0;
                for (int dr = -1; dr <= 1; dr++)
                    for (int dc = -1; dc <= 1; dc++)
                        if (!(dr == 0 && dc == 0) && r + dr >= 0 && r + dr < 8 && c + dc >= 0 && c + dc < 8)
                            cnt += int'(b[(r + dr) * 8 + c + dc]);
                n[r * 8 + c] = (cnt == 3) || (b[r * 8 + c] && cnt == 2);
            end
        end
        return n;
    endfunction

    // Engine and LED driver models: answer start pulses after programmable delays
    always @(negedge clk) begin
        cyc++;
        i_led_done = 1'b0;
        i_eng_done = 1'b0;
        if (led_down > 0) begin
            led_down--;
            if (led_down == 0) i_led_done = 1'b1;
        end
        if (eng_down > 0) begin
            eng_down--;
            if (eng_down == 0) begin
                i_eng_done  = 1'b1;
                i_eng_board = eng_pending;
            end
        end
        if (o_led_start === 1'b1) begin
            led_cnt++;
            last_led_cyc = cyc;
            last_frame   = o_led_frame;
            led_down     = led_dly;
        end
        if (o_eng_start === 1'b1) begin
            eng_cnt++;
            last_eng_cyc = cyc;
            if (eng_mode != 2) begin
                eng_down    = eng_dly;
                eng_pending = (eng_mode == 0) ? life_next(o_board) : eng_resp;
            end
        end
    end

    task automatic wait_led(input int base, input int limit, input string tag);
        bit ok = 0;
        for (int i = 0; i < limit && !ok; i++) begin
            if (led_cnt != base) ok = 1;
            else begin @(negedge clk); #1; end
        end
        if (led_cnt != base) ok = 1;
        n_vec++;
        if (!ok) begin n_err++; $display("FAIL %s led_start timeout got none within %0d cycles", tag, limit); end
    endtask

    task automatic wait_eng(input int base, input int limit, input string tag);
        bit ok = 0;
        for (int i = 0; i < limit && !ok; i++) begin
            if (eng_cnt != base) ok = 1;
            else begin @(negedge clk); #1; end
        end
        if (eng_cnt != base) ok = 1;
        n_vec++;
        if (!ok) begin n_err++; $display("FAIL %s eng_start timeout got none within %0d cycles", tag, limit); end
    endtask

    task automatic test_reset();
        int rel;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        n_vec++;
        if (o_board !== S0 || o_led_frame !== 64'h0 || o_generation !== 16'h0) begin
            n_err++;
            $display("FAIL reset_regs got board=%h frame=%h gen=%0d want board=%h frame=0 gen=0", o_board, o_led_frame, o_generation, S0);
        end
        n_vec++;
        if ({o_stable, o_extinct, o_error, o_led_start, o_eng_start} !== 5'b0) begin
            n_err++;
            $display("FAIL reset_flags got %b want 00000", {o_stable, o_extinct, o_error, o_led_start, o_eng_start});
        end
        rel   = cyc;
        rst_n = 1'b1;
        wait_led(led_cnt, 20, "reset");
        n_vec++;
        if (last_led_cyc - rel != 2 || last_frame !== S0) begin
            n_err++;
            $display("FAIL reset_first_show got delay=%0d frame=%h want delay=2 frame=%h", last_led_cyc - rel, last_frame, S0);
        end
        exp_board = S0;
        exp_gen   = 0;
    endtask

    task automatic test_blinker();
        int prev;
        eng_mode = 0; eng_dly = 5; led_dly = 10;
        for (int g = 1; g <= 3; g++) begin
            prev = last_led_cyc;
            wait_led(led_cnt, 400, "blinker");
            exp_board = (g % 2 == 1) ? VERT : S0;
            exp_gen++;
            n_vec++;
            if (last_frame !== exp_board || o_generation !== 16'(exp_gen)) begin
                n_err++;
                $display("FAIL blinker_frame g%0d got frame=%h gen=%0d want frame=%h gen=%0d", g, last_frame, o_generation, exp_board, exp_gen);
            end
            n_vec++;
            if (last_led_cyc - prev != P + eng_dly + 3 || o_stable !== 1'b0 || o_extinct !== 1'b0) begin
                n_err++;
                $display("FAIL blinker_period g%0d got interval=%0d st=%b ex=%b want interval=%0d st=0 ex=0", g, last_led_cyc - prev, o_stable, o_extinct, P + eng_dly + 3);
            end
        end
    endtask

    task automatic test_stable_extinct();
        int prev;
        logic [63:0] nb;
        logic st, ex;
        eng_mode = 1;
        for (int k = 0; k < 8; k++) begin
            if (k < 2) nb = '0;
            else if ($urandom_range(0, 3) == 0) nb = exp_board;
            else nb = {$urandom, $urandom};
            eng_resp = nb;
            eng_dly  = $urandom_range(1, 20);
            led_dly  = $urandom_range(1, 30);
            prev = last_led_cyc;
            wait_led(led_cnt, 400, "random");
            st = (nb == exp_board);
            ex = (nb == 64'h0);
            exp_board = nb;
            exp_gen++;
            n_vec++;
            if (last_frame !== exp_board || o_generation !== 16'(exp_gen)) begin
                n_err++;
                $display("FAIL random_frame k%0d got frame=%h gen=%0d want frame=%h gen=%0d", k, last_frame, o_generation, exp_board, exp_gen);
            end
            n_vec++;
            if (o_stable !== st || o_extinct !== ex || last_led_cyc - prev != P + eng_dly + 3) begin
                n_err++;
                $display("FAIL random_flags k%0d got st=%b ex=%b interval=%0d want st=%b ex=%b interval=%0d", k, o_stable, o_extinct, last_led_cyc - prev, st, ex, P + eng_dly + 3);
            end
        end
        eng_mode = 0; eng_dly = 5; led_dly = 10;
    endtask

    task automatic test_pause_step();
        int e0, l0, s;
        wait_led(led_cnt, 400, "pause_sync");
        exp_board = life_next(exp_board);
        exp_gen++;
        s  = last_led_cyc;
        e0 = eng_cnt;
        l0 = led_cnt;
        i_pause = 1'b1;
        i_step  = 1'b1;
        @(negedge clk); #1;
        i_step  = 1'b0;
        repeat (3 * P) @(negedge clk);
        #1;
        exp_board = life_next(exp_board);
        exp_gen++;
        n_vec++;
        if (eng_cnt - e0 != 1 || led_cnt - l0 != 1) begin
            n_err++;
            $display("FAIL pause_step_count got eng=%0d led=%0d want eng=1 led=1", eng_cnt - e0, led_cnt - l0);
        end
        n_vec++;
        if (last_frame !== exp_board || o_generation !== 16'(exp_gen) || last_eng_cyc - s >= P / 2) begin
            n_err++;
            $display("FAIL pause_step_gen got frame=%h gen=%0d lat=%0d want frame=%h gen=%0d lat<%0d", last_frame, o_generation, last_eng_cyc - s, exp_board, exp_gen, P / 2);
        end
        i_pause = 1'b0;
    endtask

    task automatic test_timeout();
        int e, l0;
        eng_mode = 2;
        l0 = led_cnt;
        wait_eng(eng_cnt, 400, "timeout");
        e = last_eng_cyc;
        while (cyc < e + TO - 2) begin @(negedge clk); #1; end
        n_vec++;
        if (o_error !== 1'b0) begin n_err++; $display("FAIL timeout_early got err=%b want 0", o_error); end
        while (cyc < e + TO + 2) begin @(negedge clk); #1; end
        n_vec++;
        if (o_error !== 1'b1) begin n_err++; $display("FAIL timeout_err got err=%b want 1", o_error); end
        wait_led(l0, 20, "timeout_reshow");
        eng_mode = 0;
        n_vec++;
        if (last_frame !== exp_board || o_generation !== 16'(exp_gen) || last_led_cyc - e < TO || last_led_cyc - e > TO + 4) begin
            n_err++;
            $display("FAIL timeout_reshow got frame=%h gen=%0d at=%0d want frame=%h gen=%0d at~%0d", last_frame, o_generation, last_led_cyc - e, exp_board, exp_gen, TO + 2);
        end
        wait_led(led_cnt, 400, "after_timeout");
        exp_board = life_next(exp_board);
        exp_gen++;
        n_vec++;
        if (last_frame !== exp_board || o_generation !== 16'(exp_gen) || o_error !== 1'b1) begin
            n_err++;
            $display("FAIL error_sticky got frame=%h gen=%0d err=%b want frame=%h gen=%0d err=1", last_frame, o_generation, o_error, exp_board, exp_gen);
        end
    endtask

    task automatic test_reseed_and_reset();
        int e0, prev, rel;
        i_reseed = 1'b1;
        @(negedge clk); #1;
        i_reseed = 1'b0;
        e0   = eng_cnt;
        prev = last_led_cyc;
        wait_led(led_cnt, 400, "reseed");
        exp_board = S0;
        exp_gen   = 0;
        n_vec++;
        if (last_frame !== S0 || o_generation !== 16'h0 || o_stable !== 1'b0 || o_extinct !== 1'b0) begin
            n_err++;
            $display("FAIL reseed_state got frame=%h gen=%0d st=%b ex=%b want frame=%h gen=0 st=0 ex=0", last_frame, o_generation, o_stable, o_extinct, S0);
        end
        n_vec++;
        if (eng_cnt != e0 || last_led_cyc - prev != P + 2 || o_error !== 1'b1) begin
            n_err++;
            $display("FAIL reseed_path got eng=%0d interval=%0d err=%b want eng=0 interval=%0d err=1", eng_cnt - e0, last_led_cyc - prev, o_error, P + 2);
        end
        eng_mode = 0;
        eng_dly  = 4;
        wait_eng(eng_cnt, 400, "reset_mid");
        @(negedge clk); #1;
        rst_n = 1'b0;
        #1;
        n_vec++;
        if (o_board !== S0 || o_led_frame !== 64'h0 || o_error !== 1'b0 || o_generation !== 16'h0) begin
            n_err++;
            $display("FAIL midreset_regs got board=%h frame=%h err=%b gen=%0d want board=%h frame=0 err=0 gen=0", o_board, o_led_frame, o_error, o_generation, S0);
        end
        repeat (2) @(negedge clk);
        #1;
        rel   = cyc;
        rst_n = 1'b1;
        wait_led(led_cnt, 20, "midreset_show");
        n_vec++;
        if (last_frame !== S0 || o_generation !== 16'h0 || o_error !== 1'b0 || last_led_cyc - rel != 2) begin
            n_err++;
            $display("FAIL midreset_show got frame=%h gen=%0d err=%b delay=%0d want frame=%h gen=0 err=0 delay=2", last_frame, o_generation, o_error, last_led_cyc - rel, S0);
        end
        wait_led(led_cnt, 400, "midreset_next");
        n_vec++;
        if (last_frame !== VERT || o_generation !== 16'h1) begin
            n_err++;
            $display("FAIL midreset_next got frame=%h gen=%0d want frame=%h gen=1", last_frame, o_generation, VERT);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        rst_n       = 1'b0;
        i_pause     = 1'b0;
        i_step      = 1'b0;
        i_reseed    = 1'b0;
        i_eng_done  = 1'b0;
        i_led_done  = 1'b0;
        i_eng_board = '0;
        test_reset();
        test_blinker();
        test_stable_extinct();
        test_pause_step();
        test_timeout();
        test_reseed_and_reset();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
